// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_pkg
//  Description : Shared constants for the multi-mode VGA timing generator.
//                Holds the timing-table field indices, the default H/V
//                tables, the default sync polarities and helpers that pull
//                a field out of a packed table.
//                Table layout per mode is {bp, sync, fp, active}, with
//                active in the LSBs and mode 0 in the LSBs of the table.
//  Revision    : 1.0 - initial multi-mode release
// ============================================================================
package vga_timing_pkg;

    // Field index inside one mode entry of a timing table
    localparam int F_ACT  = 0;
    localparam int F_FP   = 1;
    localparam int F_SYNC = 2;
    localparam int F_BP   = 3;

    // Tables are widened to this many bits before field extraction so that
    // one helper serves both axes and any parameterisation up to this size.
    localparam int TBL_W = 1024;

    // Defaults for XW = 11, YW = 10, N_MODES = 2
    localparam logic [2*4*11-1:0] H_TABLE_DEF = {
        11'd80,  11'd32, 11'd48,  11'd1280,   // mode 1
        11'd208, 11'd32, 11'd175, 11'd1025    // mode 0
    };
    localparam logic [2*4*10-1:0] V_TABLE_DEF = {
        10'd13,  10'd5,  10'd3,   10'd720,    // mode 1
        10'd117, 10'd5,  10'd106, 10'd513     // mode 0
    };
    localparam logic [1:0] HPOL_DEF = 2'b11;
    localparam logic [1:0] VPOL_DEF = 2'b00;

    // Extract field f of mode m from a table whose fields are w bits wide
    function automatic int tbl_field(input logic [TBL_W-1:0] tbl,
                                     input int w, input int m, input int f);
        logic [TBL_W-1:0] s;
        s = tbl >> ((m * 4 + f) * w);
        return int'(s[31:0]) & ((1 << w) - 1);
    endfunction

    // A mode is usable when its total fits the counter and only bp may be 0
    function automatic bit mode_ok(input logic [TBL_W-1:0] tbl,
                                   input int w, input int m);
        int act, fp, sy, bp;
        act = tbl_field(tbl, w, m, F_ACT);
        fp  = tbl_field(tbl, w, m, F_FP);
        sy  = tbl_field(tbl, w, m, F_SYNC);
        bp  = tbl_field(tbl, w, m, F_BP);
        return (act + fp + sy + bp <= (1 << w)) && (act != 0) &&
               (fp != 0) && (sy != 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_axis_counter
//  Description : Next-position logic for one timing axis. Given the current
//                position and the four timing fields it produces the next
//                position, whether that next position lies inside the sync
//                window / active area, and whether this step wraps.
//  Ports       : pos       in  current position
//                active/fp/sync/bp in  timing fields of the mode in force
//                advance   in  step this axis on this cycle
//                pos_nxt   out position for the next cycle
//                in_sync   out pos_nxt inside [active+fp, active+fp+sync)
//                in_active out pos_nxt < active
//                wrap      out this step goes from the last position to 0
//  Revision    : 1.0 - initial multi-mode release
// ============================================================================
module vga_axis_counter #(
    parameter int W = 11
) (
    input  logic [W-1:0] pos,
    input  logic [W-1:0] active,
    input  logic [W-1:0] fp,
    input  logic [W-1:0] sync,
    input  logic [W-1:0] bp,
    input  logic         advance,
    output logic [W-1:0] pos_nxt,
    output logic         in_sync,
    output logic         in_active,
    output logic         wrap
);

    // Two guard bits: the sum of four W-bit fields cannot overflow
    logic [W+1:0] total;
    logic [W+1:0] sync_lo;
    logic [W+1:0] sync_hi;

    always_comb begin
        total   = {2'b00, active} + {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
        sync_lo = {2'b00, active} + {2'b00, fp};
        sync_hi = sync_lo + {2'b00, sync};

        // >= rather than == so a position outside a table can never run away
        wrap    = advance && ({2'b00, pos} >= (total - (W+2)'(1)));

        if (!advance) begin
            pos_nxt = pos;
        end else if (wrap) begin
            pos_nxt = '0;
        end else begin
            pos_nxt = pos + W'(1);
        end

        in_active = (pos_nxt < active);
        in_sync   = ({2'b00, pos_nxt} >= sync_lo) && ({2'b00, pos_nxt} < sync_hi);
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Multi-mode VGA timing generator. Produces the pixel position
//                and hsync/vsync/blank/line_start/frame_start for one of
//                N_MODES table-driven timing modes. All outputs are registers
//                computed from the next (x, y), so every flag describes the
//                same pixel as the x/y shown in that cycle. A new mode is
//                taken from mode_sel only on the last pixel of a frame.
//  Ports       : clk, rst (sync, active-high), mode_sel, mode_cur, x, y,
//                hsync, vsync, blank, line_start, frame_start,
//                frame_cnt (only with VGA_TIMING_FRAME_CNT_EN defined)
//  Options     : VGA_TIMING_FRAME_CNT_EN - adds a wrapping frame counter
//  Revision    : 1.0 - initial multi-mode release
// ============================================================================
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int XW         = 11,
    parameter int YW         = 10,
    parameter int N_MODES    = 2,
    parameter int MW         = (N_MODES > 1) ? $clog2(N_MODES) : 1,
    parameter logic [N_MODES*4*XW-1:0] H_TABLE = H_TABLE_DEF,
    parameter logic [N_MODES*4*YW-1:0] V_TABLE = V_TABLE_DEF,
    parameter logic [N_MODES-1:0]      HPOL    = HPOL_DEF,
    parameter logic [N_MODES-1:0]      VPOL    = VPOL_DEF,
    parameter int RESET_MODE = 0,
    parameter int FW         = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [MW-1:0] mode_sel,
    output logic [MW-1:0] mode_cur,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          blank,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FW-1:0] frame_cnt
`endif
);

    // ------------------------------------------------------------------
    // Elaboration checks on the parameter set
    // ------------------------------------------------------------------
    for (genvar m = 0; m < N_MODES; m++) begin : g_check
        if (!mode_ok(TBL_W'(H_TABLE), XW, m) || !mode_ok(TBL_W'(V_TABLE), YW, m)) begin : g_bad
            $error("vga_timing_gen: mode %0d table overflows its counter or has a zero field", m);
        end
    end
    if (RESET_MODE >= N_MODES || FW < 1) begin : g_bad_cfg
        $error("vga_timing_gen: RESET_MODE out of range or FW < 1");
    end

    // Packed view of the tables: [mode][field]
    localparam logic [N_MODES-1:0][3:0][XW-1:0] H_F = H_TABLE;
    localparam logic [N_MODES-1:0][3:0][YW-1:0] V_F = V_TABLE;

    logic [MW-1:0] mode_q,        mode_d;
    logic [XW-1:0] x_q,           x_d;
    logic [YW-1:0] y_q,           y_d;
    logic          hsync_q,       hsync_d;
    logic          vsync_q,       vsync_d;
    logic          blank_q,       blank_d;
    logic          line_start_q,  line_start_d;
    logic          frame_start_q, frame_start_d;

    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic          h_in_sync, h_in_active, h_wrap;
    logic          v_in_sync, v_in_active, v_wrap;

    // Counters are always stepped with the fields of the mode in force. When
    // a mode switch lands, the next position is (0, 0), and position 0 is
    // inside the active area and outside the sync window for every legal
    // mode, so the flags there do not depend on which mode is used.
    vga_axis_counter #(.W(XW)) u_h (
        .pos       (x_q),
        .active    (H_F[mode_q][F_ACT]),
        .fp        (H_F[mode_q][F_FP]),
        .sync      (H_F[mode_q][F_SYNC]),
        .bp        (H_F[mode_q][F_BP]),
        .advance   (1'b1),
        .pos_nxt   (x_nxt),
        .in_sync   (h_in_sync),
        .in_active (h_in_active),
        .wrap      (h_wrap)
    );

    vga_axis_counter #(.W(YW)) u_v (
        .pos       (y_q),
        .active    (V_F[mode_q][F_ACT]),
        .fp        (V_F[mode_q][F_FP]),
        .sync      (V_F[mode_q][F_SYNC]),
        .bp        (V_F[mode_q][F_BP]),
        .advance   (h_wrap),
        .pos_nxt   (y_nxt),
        .in_sync   (v_in_sync),
        .in_active (v_in_active),
        .wrap      (v_wrap)
    );

    always_comb begin
        // v_wrap only fires when h_wrap does: it marks the last pixel of the frame
        mode_d = mode_q;
        if (v_wrap && (32'(mode_sel) < 32'(N_MODES))) begin
            mode_d = mode_sel;
        end

        x_d           = x_nxt;
        y_d           = y_nxt;
        // Polarity follows the mode that will govern the next pixel
        hsync_d       = h_in_sync ? HPOL[mode_d] : ~HPOL[mode_d];
        vsync_d       = v_in_sync ? VPOL[mode_d] : ~VPOL[mode_d];
        blank_d       = ~(h_in_active & v_in_active);
        line_start_d  = (x_nxt == '0);
        frame_start_d = line_start_d & (y_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q        <= MW'(RESET_MODE);
            x_q           <= '0;
            y_q           <= '0;
            hsync_q       <= ~HPOL[RESET_MODE];
            vsync_q       <= ~VPOL[RESET_MODE];
            blank_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_q       <= blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign mode_cur    = mode_q;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign blank       = blank_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + FW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
